// File: rtl/stepper_move_controller_if.sv
// Move-command handshake between the drive-level control logic (master)
// and the move sequencer (slave).
interface stepper_move_controller_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_move_controller.sv
// Move sequencer: turns a (direction, step count) command into a trapezoidal
// train of single-cycle step_clk pulses for the stepper FSM.
module stepper_move_controller #(
    parameter int CNT_W        = 16,
    parameter int DIV_W        = 16,
    parameter int START_PERIOD = 4000,
    parameter int MIN_PERIOD   = 500,
    parameter int ACCEL_DEC    = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    stepper_move_controller_if.slave  cmd,
    input  logic                      abort,
    output logic                      step_clk,
    output logic                      direction,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [CNT_W-1:0]          steps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] START_P = DIV_W'(START_PERIOD);
    localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_PERIOD);
    localparam logic [DIV_W-1:0] DEC_P   = DIV_W'(ACCEL_DEC);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] interval_q;
    logic [CNT_W-1:0] ramp_q;

    logic             accept;
    logic             running;
    logic             step_due;
    logic [CNT_W-1:0] left_next;
    logic [CNT_W-1:0] ramp_next;
    logic             accel_turn;
    logic             cruise_turn;
    logic             at_floor;
    logic [DIV_W:0]   period_sum;
    logic [DIV_W-1:0] period_up;
    logic [DIV_W-1:0] period_dn;

    assign accept  = cmd.cmd_valid && (state_q == S_IDLE);
    assign running = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);

    // step_clk is registered, so a step is due one cycle before its pulse shows.
    assign step_due = running && !abort && (steps_left != '0)
                      && (interval_q == period_q - DIV_ONE);

    assign left_next   = steps_left - CNT_ONE;
    assign ramp_next   = ramp_q + CNT_ONE;
    assign accel_turn  = left_next <= ramp_next;
    assign cruise_turn = left_next <= ramp_q;

    // Ramp arithmetic in DIV_W+1 bits so neither direction can wrap.
    assign period_sum = {1'b0, period_q} + {1'b0, DEC_P};
    assign period_up  = (period_sum >= {1'b0, START_P}) ? START_P : period_sum[DIV_W-1:0];
    assign at_floor   = {1'b0, period_q} <= ({1'b0, MIN_P} + {1'b0, DEC_P});
    assign period_dn  = period_q - DEC_P;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (cmd.cmd_steps == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = abort ? S_DONE : S_ACCEL;
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (abort || (steps_left == '0)) begin
                    state_d = S_DONE;
                end else if (step_due) begin
                    if (state_q == S_ACCEL) begin
                        if (accel_turn) begin
                            state_d = S_DECEL;
                        end else if (at_floor) begin
                            state_d = S_CRUISE;
                        end
                    end else if ((state_q == S_CRUISE) && cruise_turn) begin
                        state_d = S_DECEL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE) && (state_q != S_DONE);
        done          = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_clk   <= 1'b0;
            direction  <= 1'b0;
            aborted    <= 1'b0;
            steps_left <= '0;
            period_q   <= START_P;
            interval_q <= '0;
            ramp_q     <= '0;
        end else begin
            step_clk <= step_due;
            if (accept) begin
                direction  <= cmd.cmd_dir;
                steps_left <= cmd.cmd_steps;
                period_q   <= START_P;
                ramp_q     <= '0;
                interval_q <= '0;
                aborted    <= 1'b0;
            end else if ((state_q == S_SETUP) || running) begin
                // The SETUP cycle is counted as the first cycle of the opening interval.
                if (abort) begin
                    aborted <= 1'b1;
                end else if (step_due) begin
                    interval_q <= '0;
                    steps_left <= left_next;
                    unique case (state_q)
                        S_ACCEL: begin
                            ramp_q <= ramp_next;
                            if (!accel_turn) begin
                                period_q <= at_floor ? MIN_P : period_dn;
                            end
                        end
                        S_CRUISE: begin
                            if (cruise_turn) begin
                                period_q <= period_up;
                            end
                        end
                        default: begin
                            period_q <= period_up;
                        end
                    endcase
                end else begin
                    interval_q <= interval_q + DIV_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_stepper_move_controller.sv
// Self-checking bench for stepper_move_controller: directed profile, abort,
// handshake and reset scenarios plus randomized moves against a profile model.
module tb_stepper_move_controller;

    localparam int START = 40;
    localparam int MINP  = 10;
    localparam int DEC   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic        step_clk;
    logic        direction;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] steps_left;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int pulse_cyc[$];
    int done_cyc[$];
    bit done_abt[$];

    stepper_move_controller_if #(.CNT_W(16)) cmd_if ();

    stepper_move_controller #(
        .CNT_W(16),
        .DIV_W(16),
        .START_PERIOD(START),
        .MIN_PERIOD(MINP),
        .ACCEL_DEC(DEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cmd_if),
        .abort(abort),
        .step_clk(step_clk),
        .direction(direction),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_clk === 1'b1) pulse_cyc.push_back(cyc);
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_abt.push_back(aborted);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pulse_cyc.delete();
        done_cyc.delete();
        done_abt.delete();
    endtask

    // Step intervals of an n-step move, straight from the ramp rules.
    function automatic void build_profile(input int n, output int iv[$]);
        int    period = START;
        int    ramp   = 0;
        int    left   = n;
        string phase  = "accel";
        iv = {};
        for (int i = 0; i < n; i++) begin
            iv.push_back(period);
            left--;
            if (phase == "accel") begin
                ramp++;
                if (left <= ramp) begin
                    phase = "decel";
                end else if (period - DEC <= MINP) begin
                    period = MINP;
                    phase  = "cruise";
                end else begin
                    period = period - DEC;
                end
            end else if (phase == "cruise") begin
                if (left <= ramp) begin
                    period = (period + DEC > START) ? START : period + DEC;
                    phase  = "decel";
                end
            end else begin
                period = (period + DEC > START) ? START : period + DEC;
            end
        end
    endfunction

    // Present a command and hold it until accepted; acc is the cycle after the accept edge.
    task automatic send(input bit dir, input int n, output int acc);
        int w = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = 16'(n);
        while (cmd_if.cmd_ready !== 1'b1 && w < 3000) begin
            tick();
            w++;
        end
        check("accept wait", cmd_if.cmd_ready, 1);
        tick();
        acc = cyc;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int w = 0;
        while (done_cyc.size() == 0 && w < budget) begin
            tick();
            w++;
        end
        check({tag, " done seen"}, done_cyc.size() != 0, 1);
    endtask

    task automatic verify(input string tag, input int acc, input int n);
        int iv[$];
        int t;
        build_profile(n, iv);
        check({tag, " pulse count"}, pulse_cyc.size(), n);
        t = acc;
        foreach (iv[i]) begin
            t += iv[i];
            if (i < pulse_cyc.size()) check($sformatf("%s pulse%0d cycle", tag, i), pulse_cyc[i], t);
        end
        check({tag, " done count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) begin
            check({tag, " done cycle"}, done_cyc[0], (n == 0) ? acc : t + 1);
            check({tag, " aborted"}, done_abt[0], 0);
        end
    endtask

    task automatic run_and_verify(input string tag, input bit dir, input int n);
        int acc;
        clear_mon();
        send(dir, n, acc);
        check({tag, " direction"}, direction, dir);
        check({tag, " steps_left at accept"}, steps_left, n);
        check({tag, " ready low"}, cmd_if.cmd_ready, 0);
        check({tag, " busy"}, busy, n != 0);
        wait_done(tag, 3000);
        verify(tag, acc, n);
        tick();
        check({tag, " ready back"}, cmd_if.cmd_ready, 1);
        check({tag, " done cleared"}, done, 0);
        check({tag, " steps_left end"}, steps_left, 0);
    endtask

    initial begin
        int acc;
        int acc2;
        rst              = 1'b0;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = '0;

        repeat (3) tick();
        check("rst step_clk", step_clk, 0);
        check("rst direction", direction, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst aborted", aborted, 0);
        check("rst steps_left", steps_left, 0);
        check("rst cmd_ready", cmd_if.cmd_ready, 1);
        rst = 1'b1;
        clear_mon();
        repeat (100) tick();
        check("idle no pulses", pulse_cyc.size(), 0);

        // Abort is ignored while idle.
        abort = 1'b1;
        repeat (2) tick();
        check("idle abort ready", cmd_if.cmd_ready, 1);
        check("idle abort done", done, 0);
        abort = 1'b0;

        run_and_verify("trapezoid", 1'b1, 10);
        run_and_verify("triangle", 1'b0, 4);
        run_and_verify("single", 1'b1, 1);
        run_and_verify("zero", 1'b0, 0);

        // Abort in the cycle the third step is due (pulse would show at acc+90).
        clear_mon();
        send(1'b1, 10, acc);
        while (cyc < acc + 89) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort done", done, 1);
        check("abort aborted", aborted, 1);
        check("abort step_clk", step_clk, 0);
        check("abort steps_left", steps_left, 8);
        check("abort busy", busy, 0);
        check("abort pulse count", pulse_cyc.size(), 2);
        if (pulse_cyc.size() >= 2) begin
            check("abort pulse0", pulse_cyc[0], acc + 40);
            check("abort pulse1", pulse_cyc[1], acc + 70);
        end
        tick();
        check("abort ready back", cmd_if.cmd_ready, 1);
        repeat (50) tick();
        check("abort no later pulses", pulse_cyc.size(), 2);

        // Second command held while the first move runs.
        clear_mon();
        send(1'b1, 4, acc);
        send(1'b0, 3, acc2);
        check("hs done count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check("hs second accept", acc2, done_cyc[0] + 2);
        verify("hs first", acc, 4);
        check("hs second direction", direction, 0);
        check("hs second steps_left", steps_left, 3);
        clear_mon();
        wait_done("hs second", 3000);
        verify("hs second", acc2, 3);
        tick();

        for (int r = 0; r < 8; r++) begin
            int n;
            bit d;
            n = $urandom_range(0, 30);
            d = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) tick();
            run_and_verify($sformatf("rnd%0d", r), d, n);
        end

        // Reset while a cruise pulse is on the wire.
        clear_mon();
        send(1'b1, 10, acc);
        while (cyc < acc + 110) tick();
        check("mid rst pulse high", step_clk, 1);
        rst = 1'b0;
        #1;
        check("mid rst step_clk", step_clk, 0);
        check("mid rst busy", busy, 0);
        check("mid rst ready", cmd_if.cmd_ready, 1);
        check("mid rst steps_left", steps_left, 0);
        check("mid rst direction", direction, 0);
        repeat (2) tick();
        rst = 1'b1;
        clear_mon();
        repeat (100) tick();
        check("post rst no pulses", pulse_cyc.size(), 0);
        check("post rst ready", cmd_if.cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
